// File: rtl/sockit_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : sockit_i2c_slave
// Brief    : I2C target with 7-bit address match, byte-stream rx/tx ports,
//            open-drain enables and optional SCL stretching on empty tx.
// Revision : 1.0 - initial release
// ============================================================================
module sockit_i2c_slave #(
   parameter logic [6:0] ADR     = 7'h2a,
   parameter logic       STRETCH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_e,
   output logic       sda_e,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_WR_DATA  = 3'd3,
      S_WR_ACK   = 3'd4,
      S_RD_DATA  = 3'd5,
      S_RD_ACK   = 3'd6,
      S_IGNORE   = 3'd7
   } state_t;

   // Bit counter values used inside ACK states to track the ACK bit phases.
   localparam logic [3:0] c_cnt_last  = 4'd7;
   localparam logic [3:0] c_cnt_byte  = 4'd8;
   localparam logic [3:0] c_cnt_ack   = 4'd9;
   localparam logic [3:0] c_cnt_acked = 4'd10;

   logic       r_scl_s1, r_scl_s2, r_scl_h;
   logic       r_sda_s1, r_sda_s2, r_sda_h;

   state_t     r_state, w_state;
   logic [3:0] r_cnt, w_cnt;
   logic [7:0] r_shift, w_shift;
   logic       r_rw, w_rw;
   logic       r_ack, w_ack;
   logic       r_pend, w_pend;
   logic       r_sda_e, w_sda_e;
   logic       r_scl_e, w_scl_e;
   logic [7:0] r_rx_data, w_rx_data;
   logic       r_rx_valid, w_rx_valid;
   logic       r_tx_ready, w_tx_ready;
   logic       r_busy, w_busy;
   logic       w_load;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_rx_held;
   logic [7:0] w_shift_in;

   // Two-flop synchronizer plus one history flop per line; idle bus is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_h  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_h  <= 1'b1;
      end else begin
         r_scl_s1 <= scl_i;
         r_scl_s2 <= r_scl_s1;
         r_scl_h  <= r_scl_s2;
         r_sda_s1 <= sda_i;
         r_sda_s2 <= r_sda_s1;
         r_sda_h  <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_h;
   assign w_scl_fall = ~r_scl_s2 & r_scl_h;
   assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
   assign w_shift_in = {r_shift[6:0], r_sda_s2};
   // rx_valid as seen after this cycle's consume; overflow is judged on it.
   assign w_rx_held  = r_rx_valid & ~rx_ready;

   // State register and all protocol registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_shift    <= 8'h00;
         r_rw       <= 1'b0;
         r_ack      <= 1'b0;
         r_pend     <= 1'b0;
         r_sda_e    <= 1'b0;
         r_scl_e    <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_shift    <= w_shift;
         r_rw       <= w_rw;
         r_ack      <= w_ack;
         r_pend     <= w_pend;
         r_sda_e    <= w_sda_e;
         r_scl_e    <= w_scl_e;
         r_rx_data  <= w_rx_data;
         r_rx_valid <= w_rx_valid;
         r_tx_ready <= w_tx_ready;
         r_busy     <= w_busy;
      end
   end

   // Next-state logic; START/STOP override any bit-level activity.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_shift    = r_shift;
      w_rw       = r_rw;
      w_ack      = r_ack;
      w_pend     = r_pend;
      w_sda_e    = r_sda_e;
      w_scl_e    = r_scl_e;
      w_rx_data  = r_rx_data;
      w_rx_valid = w_rx_held;
      w_tx_ready = 1'b0;
      w_busy     = r_busy;
      w_load     = 1'b0;

      if (w_start) begin
         w_state = S_ADDR;
         w_cnt   = 4'd0;
         w_busy  = 1'b1;
         w_sda_e = 1'b0;
         w_scl_e = 1'b0;
         w_pend  = 1'b0;
      end else if (w_stop) begin
         w_state = S_IDLE;
         w_cnt   = 4'd0;
         w_busy  = 1'b0;
         w_sda_e = 1'b0;
         w_scl_e = 1'b0;
         w_pend  = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift = w_shift_in;
                  w_cnt   = r_cnt + 4'd1;
                  if (r_cnt == c_cnt_last) begin
                     w_rw = r_sda_s2;
                     if (r_shift[6:0] == ADR) begin
                        w_state = S_ADDR_ACK;
                        w_ack   = 1'b1;
                     end else begin
                        w_state = S_IGNORE;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_WR_ACK: begin
               if (w_scl_fall) begin
                  if (r_cnt == c_cnt_byte) begin
                     w_sda_e = r_ack;
                     w_cnt   = c_cnt_ack;
                  end else begin
                     w_sda_e = 1'b0;
                     w_cnt   = 4'd0;
                     if ((r_state == S_ADDR_ACK) && r_rw) begin
                        w_state = S_RD_DATA;
                        w_load  = 1'b1;
                     end else begin
                        w_state = S_WR_DATA;
                     end
                  end
               end
            end
            S_WR_DATA: begin
               if (w_scl_rise) begin
                  w_shift = w_shift_in;
                  w_cnt   = r_cnt + 4'd1;
                  if (r_cnt == c_cnt_last) begin
                     w_state = S_WR_ACK;
                     w_ack   = ~w_rx_held;
                     if (!w_rx_held) begin
                        w_rx_data  = w_shift_in;
                        w_rx_valid = 1'b1;
                     end
                  end
               end
            end
            S_RD_DATA: begin
               if (r_pend) begin
                  // Stretching: SCL is held, so only tx_valid can move us on.
                  if (tx_valid) begin
                     w_shift    = tx_data;
                     w_tx_ready = 1'b1;
                     w_sda_e    = ~tx_data[7];
                     w_scl_e    = 1'b0;
                     w_pend     = 1'b0;
                  end
               end else if (w_scl_rise) begin
                  w_shift = w_shift_in;
                  w_cnt   = r_cnt + 4'd1;
                  if (r_cnt == c_cnt_last) begin
                     w_state = S_RD_ACK;
                  end
               end else if (w_scl_fall) begin
                  w_sda_e = ~r_shift[7];
               end
            end
            S_RD_ACK: begin
               if (w_scl_fall) begin
                  if (r_cnt == c_cnt_byte) begin
                     w_sda_e = 1'b0;
                     w_cnt   = c_cnt_ack;
                  end else if (r_cnt == c_cnt_acked) begin
                     w_state = S_RD_DATA;
                     w_cnt   = 4'd0;
                     w_load  = 1'b1;
                  end
               end else if (w_scl_rise && (r_cnt == c_cnt_ack)) begin
                  if (r_sda_s2) begin
                     w_state = S_IGNORE;
                  end else begin
                     w_cnt = c_cnt_acked;
                  end
               end
            end
            default: begin
            end
         endcase

         // Start of a read byte: take tx data, stretch, or fall back to 0xff.
         if (w_load) begin
            if (tx_valid) begin
               w_shift    = tx_data;
               w_tx_ready = 1'b1;
               w_sda_e    = ~tx_data[7];
            end else if (STRETCH) begin
               w_scl_e = 1'b1;
               w_pend  = 1'b1;
               w_sda_e = 1'b0;
            end else begin
               w_shift = 8'hff;
               w_sda_e = 1'b0;
            end
         end
      end
   end

   assign scl_e    = r_scl_e;
   assign sda_e    = r_sda_e;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign tx_ready = r_tx_ready;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sockit_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sockit_i2c_slave
// Brief    : Bus-level I2C master driving sockit_i2c_slave against a
//            transaction-level model of the target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sockit_i2c_slave;

   localparam logic [6:0] c_adr = 7'h2a;
   localparam int c_q      = 5;
   localparam int PH_IDLE  = 0;
   localparam int PH_ADDR  = 1;
   localparam int PH_WR    = 2;
   localparam int PH_RD    = 3;
   localparam int PH_IGN   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_o = 1'b1;
   logic       sda_o = 1'b1;
   logic       rx_ready = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       scl_e, sda_e, rx_valid, tx_ready, busy;
   logic [7:0] rx_data;
   logic       scl_bus, sda_bus;

   assign scl_bus = scl_o & ~scl_e;
   assign sda_bus = sda_o & ~sda_e;

   sockit_i2c_slave #(.ADR(c_adr), .STRETCH(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl_i    (scl_bus),
      .sda_i    (sda_bus),
      .scl_e    (scl_e),
      .sda_e    (sda_e),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Transaction-level model of what the target must show.
   int         m_phase = PH_IDLE;
   logic       m_busy = 1'b0;
   logic       m_rx_valid = 1'b0;
   logic [7:0] m_rx_data = 8'h00;
   logic       m_sda_e = 1'b0;
   logic       m_scl_e = 1'b0;
   int         m_loads = 0;
   logic [7:0] m_rdq[$];
   logic [7:0] txq[$];
   bit         chk_en = 1'b0;
   int         tx_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison while the bus is in a stable phase.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("sda_e", sda_e, m_sda_e);
         chk("scl_e", scl_e, m_scl_e);
         chk("busy", busy, m_busy);
         chk("rx_valid", rx_valid, m_rx_valid);
         chk("rx_data", rx_data, m_rx_data);
         chk("tx_ready_idle", tx_ready, 1'b0);
      end
   end

   always @(negedge clk) begin
      if (tx_ready) tx_pulses++;
   end

   // System-side byte producer feeding tx from a queue.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tx_ready && txq.size() > 0) void'(txq.pop_front());
         tx_valid = (txq.size() > 0);
         tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
      end
   end

   task automatic raise_scl;
      int n;
      n = 0;
      scl_o = 1'b1;
      wclk(1);
      while (scl_bus !== 1'b1 && n < 2000) begin
         wclk(1);
         n++;
      end
      chk("scl_high", scl_bus, 1'b1);
   endtask

   // One SCL period; the window during SCL high checks the model.
   task automatic clock_bit(input logic drive, input logic exp_sda_e, output logic sampled);
      wclk(c_q);
      sda_o = drive;
      wclk(c_q);
      raise_scl();
      m_sda_e = exp_sda_e;
      m_scl_e = 1'b0;
      wclk(c_q);
      chk_en  = 1'b1;
      sampled = sda_bus;
      wclk(c_q);
      chk_en  = 1'b0;
      scl_o   = 1'b0;
   endtask

   task automatic do_start;
      sda_o = 1'b1;
      wclk(c_q);
      raise_scl();
      wclk(c_q);
      sda_o   = 1'b0;
      m_busy  = 1'b1;
      m_phase = PH_ADDR;
      m_sda_e = 1'b0;
      m_scl_e = 1'b0;
      wclk(4);
      chk_en = 1'b1;
      wclk(c_q);
      chk_en = 1'b0;
      scl_o  = 1'b0;
   endtask

   task automatic do_stop;
      wclk(c_q);
      sda_o = 1'b0;
      wclk(c_q);
      raise_scl();
      wclk(c_q);
      sda_o   = 1'b1;
      m_busy  = 1'b0;
      m_phase = PH_IDLE;
      m_sda_e = 1'b0;
      m_scl_e = 1'b0;
      wclk(4);
      chk_en = 1'b1;
      wclk(c_q);
      chk_en = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      logic ack, cap, s;
      ack = 1'b0;
      cap = 1'b0;
      if (m_phase == PH_ADDR) begin
         if (b[7:1] == c_adr) begin
            ack     = 1'b1;
            m_phase = b[0] ? PH_RD : PH_WR;
         end else begin
            m_phase = PH_IGN;
         end
      end else if (m_phase == PH_WR) begin
         cap = !m_rx_valid;
         ack = cap;
      end
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && cap) begin
            m_rx_valid = 1'b1;
            m_rx_data  = b;
         end
         clock_bit(b[i], 1'b0, s);
      end
      clock_bit(1'b1, ack, s);
      acked = ~s;
      chk("ack_bit", acked, ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] got);
      logic       drv, s;
      logic [7:0] d;
      drv = (m_phase == PH_RD);
      d   = 8'hff;
      if (drv) begin
         d = m_rdq.pop_front();
         m_loads++;
      end
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, drv ? ~d[i] : 1'b0, s);
         got[i] = s;
      end
      clock_bit(~mack, 1'b0, s);
      if (drv && !mack) m_phase = PH_IGN;
      chk("rd_byte", got, d);
   endtask

   task automatic consume;
      rx_ready = 1'b1;
      wclk(1);
      rx_ready   = 1'b0;
      m_rx_valid = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a;
      logic [7:0] got, b;
      logic [6:0] adr;
      logic       rw;
      int         n, t0;

      // Reset state
      wclk(3);
      chk("rst_sda_e", sda_e, 1'b0);
      chk("rst_scl_e", scl_e, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_tx_ready", tx_ready, 1'b0);
      rst = 1'b0;
      wclk(5);

      // Write 0xa5 to our address
      do_start();
      send_byte(8'h54, a);
      chk("t1_addr_ack", a, 1'b1);
      send_byte(8'ha5, a);
      chk("t1_data_ack", a, 1'b1);
      do_stop();
      chk("t1_rx_data", rx_data, 8'ha5);
      chk("t1_rx_valid", rx_valid, 1'b1);
      chk("t1_busy", busy, 1'b0);
      consume();
      wclk(1);
      chk("t1_consumed", rx_valid, 1'b0);

      // Address mismatch
      do_start();
      send_byte(8'h22, a);
      chk("t2_addr_nack", a, 1'b0);
      send_byte(8'hff, a);
      do_stop();
      chk("t2_rx_valid", rx_valid, 1'b0);

      // Read with clock stretching
      m_rdq.push_back(8'h3c);
      t0 = tx_pulses;
      do_start();
      send_byte(8'h55, a);
      chk("t3_addr_ack", a, 1'b1);
      wclk(4);
      m_scl_e = 1'b1;
      m_sda_e = 1'b0;
      chk_en  = 1'b1;
      wclk(34);
      chk_en  = 1'b0;
      chk("t3_no_early_txr", tx_pulses, t0);
      txq.push_back(8'h3c);
      n = 0;
      while (tx_pulses == t0 && n < 20) begin
         wclk(1);
         n++;
      end
      chk("t3_tx_ready", tx_pulses, t0 + 1);
      wclk(1);
      chk("t3_scl_rel", scl_e, 1'b0);
      chk("t3_msb", sda_e, 1'b1);
      recv_byte(1'b0, got);
      chk("t3_byte", got, 8'h3c);
      do_stop();
      chk("t3_pulses", tx_pulses, m_loads);

      // Overflow
      do_start();
      send_byte(8'h54, a);
      send_byte(8'h11, a);
      chk("t4_ack1", a, 1'b1);
      send_byte(8'h22, a);
      chk("t4_nack2", a, 1'b0);
      do_stop();
      chk("t4_rx_data", rx_data, 8'h11);
      consume();

      // Repeated START: write then read two bytes
      m_rdq.push_back(8'hc3);
      m_rdq.push_back(8'h5a);
      txq.push_back(8'hc3);
      txq.push_back(8'h5a);
      t0 = tx_pulses;
      do_start();
      send_byte(8'h54, a);
      send_byte(8'h07, a);
      do_start();
      send_byte(8'h55, a);
      recv_byte(1'b1, got);
      chk("t5_byte0", got, 8'hc3);
      recv_byte(1'b0, got);
      chk("t5_byte1", got, 8'h5a);
      do_stop();
      chk("t5_rx_data", rx_data, 8'h07);
      chk("t5_pulses", tx_pulses - t0, 2);

      // Reset in the middle of a read byte
      m_rdq.push_back(8'h00);
      txq.push_back(8'h00);
      do_start();
      send_byte(8'h55, a);
      wclk(5);
      chk("t6_drive", sda_e, 1'b1);
      rst = 1'b1;
      wclk(1);
      chk("t6_sda_e", sda_e, 1'b0);
      chk("t6_scl_e", scl_e, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_rx_valid", rx_valid, 1'b0);
      rst = 1'b0;
      void'(m_rdq.pop_front());
      m_loads++;
      m_phase    = PH_IDLE;
      m_busy     = 1'b0;
      m_rx_valid = 1'b0;
      m_rx_data  = 8'h00;
      do_start();
      send_byte(8'h54, a);
      chk("t6_addr_ack", a, 1'b1);
      send_byte(8'h66, a);
      do_stop();
      chk("t6_rx_data", rx_data, 8'h66);

      // Randomized transactions
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(1, 0) == 1) consume();
         if ($urandom_range(3, 0) != 0) begin
            adr = c_adr;
         end else begin
            do adr = 7'($urandom_range(127, 0)); while (adr == c_adr);
         end
         rw = 1'($urandom_range(1, 0));
         n  = $urandom_range(3, 1);
         if (adr == c_adr && rw) begin
            for (int i = 0; i < n; i++) begin
               b = 8'($urandom_range(255, 0));
               m_rdq.push_back(b);
               txq.push_back(b);
            end
         end
         do_start();
         send_byte({adr, rw}, a);
         for (int i = 0; i < n; i++) begin
            if (rw) recv_byte(i != n - 1, got);
            else send_byte(8'($urandom_range(255, 0)), a);
         end
         do_stop();
         chk("rand_pulses", tx_pulses, m_loads);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
